pll_lock_sequencer: RTL

- Sequences the video-clock PLL from the 50 MHz reference domain.
- Issues a timed PLL reset and waits for lock with a timeout and a bounded retry count.
- Debounces `locked`, then releases `sys_rst_n`/`ready` to downstream video logic.
- On lock loss during operation, re-arms the PLL automatically and counts the events.

---
 rtl/pll_lock_sequencer_if.sv | 22 ++
 rtl/pll_lock_sequencer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the video-PLL lock sequencer and its environment.
// The sequencer attaches through the slave modport; the driving side uses master.
interface pll_lock_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [2:0] state;
  logic [7:0] lock_loss_cnt;

  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_rst_n, ready, fault, state, lock_loss_cnt
  );

  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_rst_n, ready, fault, state, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Video PLL reset/lock sequencer in the refclk domain: timed PLL reset, lock wait with retries,
// lock debounce, downstream reset release. Define PLL_LOCK_LOSS_CNT_EN to build the lock-loss counter.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  pll_lock_sequencer_if.slave  bus
);

  localparam int unsigned MAX_A   = (RST_CYCLES > LOCK_STABLE_CYCLES) ? RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TW_RAW  = $clog2(MAX_CYC);
  localparam int unsigned TW      = (TW_RAW < 1) ? 1 : TW_RAW;
  localparam int unsigned RW_RAW  = $clog2(MAX_RETRIES + 1);
  localparam int unsigned RW      = (RW_RAW < 1) ? 1 : RW_RAW;

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retries_q, retries_d;
  logic [1:0]    sync_q;
  logic          locked_s;
  logic          pll_rst_d, run_d, fault_d;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], bus.pll_locked};
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_RESET_PLL;
      timer_q       <= '0;
      retries_q     <= '0;
      bus.pll_rst   <= 1'b1;
      bus.sys_rst_n <= 1'b0;
      bus.ready     <= 1'b0;
      bus.fault     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      retries_q     <= retries_d;
      bus.pll_rst   <= pll_rst_d;
      bus.sys_rst_n <= run_d;
      bus.ready     <= run_d;
      bus.fault     <= fault_d;
    end
  end

  // Next state; outputs are decoded from the next state so they line up with state_q
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retries_d = retries_q;

    if (bus.restart) begin
      state_d   = S_RESET_PLL;
      timer_d   = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (timer_q == TW'(RST_CYCLES - 1)) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = S_STABILIZE;
            timer_d = '0;
          end else if (timer_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            retries_d = retries_q + RW'(1);
            timer_d   = '0;
            state_d   = (retries_d == RW'(MAX_RETRIES)) ? S_FAULT : S_RESET_PLL;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_STABILIZE: begin
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q == TW'(LOCK_STABLE_CYCLES - 1)) begin
            state_d   = S_RUN;
            timer_d   = '0;
            retries_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_RUN: begin
          if (!locked_s) begin
            state_d = S_RESET_PLL;
            timer_d = '0;
          end
        end
        S_FAULT: begin
          state_d = S_FAULT;
        end
        default: begin
          state_d = S_RESET_PLL;
          timer_d = '0;
        end
      endcase
    end

    pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    run_d     = (state_d == S_RUN);
    fault_d   = (state_d == S_FAULT);
  end

  assign bus.state = state_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] lock_loss_q;
  logic       lock_loss_ev;

  // A restart wins over a coincident lock loss, so it is not counted
  assign lock_loss_ev = (state_q == S_RUN) && !locked_s && !bus.restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                                  lock_loss_q <= 8'd0;
    else if (lock_loss_ev && lock_loss_q != 8'hFF) lock_loss_q <= lock_loss_q + 8'd1;
  end

  assign bus.lock_loss_cnt = lock_loss_q;
`else
  assign bus.lock_loss_cnt = 8'd0;
`endif

endmodule
